// File: rtl/lc3b_pmem_responder.sv
// Line-granular physical memory responder: one 128-bit read or write at a time,
// a fixed access latency, and a single-cycle pmem_resp. Optional macro LC3B_PMEM_PROTO_CHECK_EN.
module lc3b_pmem_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [127:0] pmem_rdata,
  output logic         pmem_error,
  output logic [1:0]   dbg_state
);

  // Handshake: a request (read|write) is held by the initiator until pmem_resp,
  // which is high for exactly one cycle; the following DONE cycle ignores inputs.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [127:0]            wdata_q, wdata_d;
  logic                    wr_q, wr_d;
  logic [127:0]            rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    mem_we;
  logic [127:0]            rd_line;
  logic                    resp;

`ifdef LC3B_PMEM_PROTO_CHECK_EN
  logic [11:0]             tag_q, tag_d;
  logic [1:0]              req_q, req_d;
`endif

  logic [127:0] mem [0:(1<<DEPTH_LOG2)-1];

  logic unused_addr;
  assign unused_addr = ^pmem_address;

  assign rd_line = mem[idx_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    resp    = 1'b0;
`ifdef LC3B_PMEM_PROTO_CHECK_EN
    tag_d   = tag_q;
    req_d   = req_q;
`endif
    case (state_q)
      IDLE: begin
        if (pmem_read || pmem_write) begin
          idx_d   = pmem_address[4 +: DEPTH_LOG2];
          wdata_d = pmem_wdata;
          wr_d    = pmem_write;
          cnt_d   = 4'(LATENCY - 1);
          state_d = BUSY;
          if (pmem_read && pmem_write) err_d = 1'b1;
`ifdef LC3B_PMEM_PROTO_CHECK_EN
          tag_d   = pmem_address[15:4];
          req_d   = {pmem_read, pmem_write};
`endif
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          resp    = 1'b1;
          state_d = DONE;
          if (wr_q) mem_we  = 1'b1;
          else      rdata_d = rd_line;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
`ifdef LC3B_PMEM_PROTO_CHECK_EN
        // Any drift of the held request flags an error; service uses latched values.
        if ((pmem_address[15:4] != tag_q) || ({pmem_read, pmem_write} != req_q) ||
            (wr_q && (pmem_wdata != wdata_q)))
          err_d = 1'b1;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef LC3B_PMEM_PROTO_CHECK_EN
      tag_q   <= '0;
      req_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef LC3B_PMEM_PROTO_CHECK_EN
      tag_q   <= tag_d;
      req_q   <= req_d;
`endif
    end
  end

  // Storage is deliberately unreset; reset forces IDLE so no write can commit.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= wdata_q;
  end

  assign pmem_resp  = resp;
  assign pmem_rdata = rdata_d;
  assign pmem_error = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_lc3b_pmem_responder.sv
// Directed bench for lc3b_pmem_responder: a scoreboard queue of expected responses
// checked by an independent monitor on the falling clock edge.
module tb_lc3b_pmem_responder;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;
  logic         pmem_error;
  logic [1:0]   dbg_state;

  lc3b_pmem_responder #(.LATENCY(LAT), .DEPTH_LOG2(8)) dut (
    .clk(clk), .rst(rst),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .pmem_error(pmem_error), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [127:0] DA = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [127:0] DB = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] DC = 128'hC0C0_C0C0_A5A5_5A5A_1234_5678_9ABC_DEF0;
  localparam logic [127:0] DD = 128'h0D0D_0D0D_FFFF_0000_7777_8888_9999_AAAA;
  localparam logic [127:0] DE = 128'hEEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE;

`ifdef LC3B_PMEM_PROTO_CHECK_EN
  localparam logic EXP_PROTO_ERR = 1'b1;
`else
  localparam logic EXP_PROTO_ERR = 1'b0;
`endif

  // scoreboard
  logic [127:0] exp_q[$];
  int           exp_cyc_q[$];
  logic         exp_rd_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int c, input logic is_rd, input logic [127:0] d);
    exp_cyc_q.push_back(c);
    exp_rd_q.push_back(is_rd);
    exp_q.push_back(d);
  endtask

  // monitor
  logic prev_resp = 1'b0;
  always @(negedge clk) begin
    if (prev_resp) chk("resp_one_cycle", {127'b0, pmem_resp}, 128'd0);
    prev_resp = pmem_resp;
    if (pmem_resp) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 128'd1, 128'd0);
      end else begin
        int          ec;
        logic        er;
        logic [127:0] ed;
        ec = exp_cyc_q.pop_front();
        er = exp_rd_q.pop_front();
        ed = exp_q.pop_front();
        chk("resp_latency", 128'(cyc), 128'(ec));
        if (er) chk("rdata", pmem_rdata, ed);
      end
    end
  end

  // driver: one operation; corrupt moves the address by one line during BUSY
  task automatic op(input logic rd, input logic wr, input logic [15:0] addr,
                    input logic [127:0] wd, input logic [127:0] exp_rd, input logic corrupt);
    bit got;
    @(posedge clk); #1;
    pmem_read = rd; pmem_write = wr; pmem_address = addr; pmem_wdata = wd;
    push_exp(cyc + LAT, rd & ~wr, exp_rd);
    got = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (corrupt && i == 1) pmem_address = addr + 16'h0010;
      if (pmem_resp) begin got = 1; break; end
    end
    if (!got) chk("resp_timeout", 128'd0, 128'd1);
    @(posedge clk); #1;
    pmem_read = 0; pmem_write = 0;
    @(posedge clk);
  endtask

  initial begin
    int c0, seen;
    rst = 1; pmem_read = 0; pmem_write = 0; pmem_address = 0; pmem_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_resp", {127'b0, pmem_resp}, 128'd0);
    chk("reset_rdata", pmem_rdata, 128'd0);
    chk("reset_error", {127'b0, pmem_error}, 128'd0);
    rst = 0;

    // write then read, held data, offset and alias
    op(0, 1, 16'h0040, DA, 128'd0, 0);
    op(1, 0, 16'h0040, 128'd0, DA, 0);
    repeat (3) @(posedge clk); #1;
    chk("rdata_held", pmem_rdata, DA);
    op(1, 0, 16'h004E, 128'd0, DA, 0);
    op(0, 1, 16'h1040, DB, 128'd0, 0);
    op(1, 0, 16'h0040, 128'd0, DB, 0);
    op(0, 1, 16'h0050, DD, 128'd0, 0);
    chk("no_error_yet", {127'b0, pmem_error}, 128'd0);

    // address moved during BUSY: data still from the latched line
    op(1, 0, 16'h0040, 128'd0, DB, 1);
    #1 chk("proto_error", {127'b0, pmem_error}, {127'b0, EXP_PROTO_ERR});

    // back-to-back: read held across resp and DONE
    @(posedge clk); #1;
    pmem_read = 1; pmem_address = 16'h0050;
    c0 = cyc;
    push_exp(c0 + LAT, 1'b1, DD);
    push_exp(c0 + LAT + LAT + 2, 1'b1, DD);
    seen = 0;
    for (int i = 0; i < 40 && seen < 2; i++) begin
      @(negedge clk);
      if (pmem_resp) seen++;
    end
    chk("b2b_count", 128'(seen), 128'd2);
    @(posedge clk); #1;
    pmem_read = 0;
    repeat (2) @(posedge clk);

    // simultaneous read and write: write wins, sticky error
    op(1, 1, 16'h0060, DC, 128'd0, 0);
    #1 chk("both_error", {127'b0, pmem_error}, 128'd1);
    op(1, 0, 16'h0060, 128'd0, DC, 0);
    #1 chk("error_sticky", {127'b0, pmem_error}, 128'd1);

    // reset mid-BUSY of a write: aborted, nothing committed
    @(posedge clk); #1;
    pmem_write = 1; pmem_address = 16'h0040; pmem_wdata = DE;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("midrst_resp", {127'b0, pmem_resp}, 128'd0);
    chk("midrst_rdata", pmem_rdata, 128'd0);
    chk("midrst_error", {127'b0, pmem_error}, 128'd0);
    pmem_write = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    op(1, 0, 16'h0040, 128'd0, DB, 0);
    #1 chk("error_after_rst", {127'b0, pmem_error}, 128'd0);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lc3b_pmem_responder.md
# lc3b_pmem_responder

Memory-side responder for the cache-to-physical-memory line interface. It accepts one 128-bit line read or write at a time from the cache controller, waits a parameterised access latency, then returns a single-cycle `pmem_resp`. Line storage is built in. The block stands in for main memory under the cache and serves as the line-fill and writeback target for the L1 cache.

## Interface
Parameters:
- `LATENCY`, default 4: cycles from request acceptance to `pmem_resp`. Legal range is 1 to 15.
- `DEPTH_LOG2`, default 8: log2 of the number of 128-bit lines stored. Legal range is 1 to 12.

Ports:
- `clk`  in  1  single clock. All state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pmem_read`  in  1  line read request. Held high until `pmem_resp`.
- `pmem_write`  in  1  line write request. Held high until `pmem_resp`.
- `pmem_address`  in  16  byte address. Bits [3:0] are ignored. Bits [4+DEPTH_LOG2-1:4] select the line.
- `pmem_wdata`  in  128  write line data. Held stable until `pmem_resp`.
- `pmem_resp`  out  1  one-cycle completion pulse.
- `pmem_rdata`  out  128  read line data.
- `pmem_error`  out  1  sticky protocol error flag.

## Operation
- FSM states are `IDLE`, `BUSY` and `DONE`.
- **IDLE**
  - A request is `pmem_read | pmem_write`. When one is present, latch the address, write data and operation, load the down-counter with `LATENCY-1`, and go to `BUSY`.
  - If both `pmem_read` and `pmem_write` are high, write wins and `pmem_error` is set.
- **BUSY**
  - Decrement the counter each cycle. When the counter is 0, assert `pmem_resp` for this cycle and go to `DONE`.
  - For a read, drive `pmem_rdata` from the latched line in this cycle. `pmem_rdata` holds that value until the next read response.
  - For a write, store the latched data to the latched line at this clock edge.
- **DONE**
  - Request inputs are ignored for one cycle, because the initiator deasserts in this cycle.
  - Next state is `IDLE`.
- **Address aliasing:** address bits above the line index are ignored, so line N repeats every `2^(DEPTH_LOG2+4)` bytes.
- **Storage:** storage is not reset and its contents are undefined until written. A read of an unwritten line returns undefined data; this is not flagged.
- **Write-then-read:** a write followed by a read to the same line returns the written data. Writes are committed at the `pmem_resp` edge.
- **`pmem_error`:** once set it is cleared only by `rst`. Setting it never blocks service.

## Timing
- **Reset values:** state `IDLE`, counter 0, `pmem_resp`=0, `pmem_rdata`=0, `pmem_error`=0.
- **Reset mid-operation:** an in-flight operation is aborted. No response is issued and no write is committed.
- **Latency:** a request first seen high in IDLE at edge T produces `pmem_resp` high during cycle T+LATENCY. It is high for exactly one cycle.
- **Back-to-back requests:** the next request is accepted at the earliest at edge T+LATENCY+2, which is one DONE cycle. The minimum period per operation is therefore LATENCY+2 cycles.
- **Input sampling:** inputs are sampled only in IDLE. Changes during BUSY have no effect on the operation, unless the check feature below is compiled in.
- **Counter width:** 4 bits. It is sized for `LATENCY` ≤ 15.
- **Latency 1:** with `LATENCY`=1 the counter loads 0, and `pmem_resp` occurs in the cycle after acceptance.

## Configuration
- **Macro:** `LC3B_PMEM_PROTO_CHECK_EN`.
- **Defined:** in BUSY, the block compares `pmem_address[15:4]`, `pmem_wdata` (writes only) and the request bits against the latched values each cycle. Any mismatch, or a request dropped before `pmem_resp`, sets `pmem_error`. The operation still completes using the latched values.
- **Not defined:** the comparators are not built. `pmem_error` reflects only the simultaneous read and write case.

## Test plan
- **Reset:** `rst` high mid-BUSY → `pmem_resp`=0, `pmem_rdata`=0 and `pmem_error`=0 immediately. Storage is unchanged; a later read of that line returns the prior contents.
- **Write then read, LATENCY=4:**
  - Write 0x0123…CDEF to address 0x0040 → `pmem_resp` pulses at T+4 for one cycle.
  - Read 0x0040 → `pmem_resp` pulses at T'+4 with `pmem_rdata`=0x0123…CDEF, held after the pulse.
- **Offset and alias, DEPTH_LOG2=8:**
  - Write line A to 0x0040, then read 0x004E → returns A.
  - Write B to 0x1040 (aliases index 4), then read 0x0040 → returns B.
- **Back-to-back:** a read held continuously across `pmem_resp` and DONE is re-accepted exactly at T+6, giving a second `pmem_resp` at T+10.
- **Simultaneous read and write:** `pmem_read`=`pmem_write`=1 with data C → write performed, `pmem_error`=1 and stays 1 until `rst`.
- **Protocol check, macro defined:** change `pmem_address` from 0x0040 to 0x0050 during BUSY of a read → `pmem_error`=1 and the data returned is from 0x0040. With the macro undefined, `pmem_error` stays 0.
